// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl -- MIPS-style coprocessor-0 control block.
//
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14).
// It arbitrates commit-stage events in the order interrupt > exception > ERET
// and produces the pipeline flush / redirect request in the same cycle. It also
// runs the Count/Compare timer and synchronises the external interrupt lines.
//
// Ports
//   clk          clock
//   resetn       synchronous, active-low reset
//   ext_int      asynchronous external interrupt requests -> Cause.IP[2+i]
//   raddr/rdata  CP0 read port (combinational, from registered state only)
//   we/waddr/wdata  MTC0 write port, takes effect at the next clock edge
//   inst_valid   a valid instruction occupies the commit stage
//   exc_valid    commit-stage instruction raised a synchronous exception
//   exc_code     ExcCode of that exception
//   eret         commit-stage instruction is ERET
//   in_slot      commit-stage instruction sits in a branch delay slot
//   pc           commit-stage PC
//   badvaddr     faulting address for address-error exceptions
//   flush        pipeline flush request (event cycle)
//   redirect_pc  fetch target while flush=1, EXC_VECTOR otherwise
//   int_pending  an unmasked interrupt is present (IP & IM != 0)
// -----------------------------------------------------------------------------
module cp0_ctrl #(
  parameter int unsigned EXT_INT_W  = 6,
  parameter int unsigned TIMER_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [EXT_INT_W-1:0] ext_int,
  input  logic [4:0]           raddr,
  output logic [31:0]          rdata,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic                 inst_valid,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic                 eret,
  input  logic                 in_slot,
  input  logic [31:0]          pc,
  input  logic [31:0]          badvaddr,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic                 int_pending
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Software may only change IM[7:0], EXL and IE; every other Status bit keeps
  // its reset value for the life of the part.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;

  localparam int unsigned    PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TIMER_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]          status_q,   status_d;
  logic                 bd_q,       bd_d;
  logic [1:0]           ip_sw_q,    ip_sw_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [31:0]          epc_q,      epc_d;
  logic [31:0]          badvaddr_q, badvaddr_d;
  logic [31:0]          count_q,    count_d;
  logic [31:0]          compare_q,  compare_d;
  logic [PW-1:0]        presc_q,    presc_d;
  logic                 cmp_written_q, cmp_written_d;
  logic                 timer_irq_q,   timer_irq_d;
  logic [EXT_INT_W-1:0] sync1_q, sync2_q;

  // ---------------------------------------------------------------------------
  // Interrupt view: hardware IP bits come straight from the synchroniser and
  // the sticky timer flag, so they need no storage of their own.
  // ---------------------------------------------------------------------------
  logic [5:0]  ip_hw;
  logic [7:0]  ip;
  logic [31:0] cause_rd;

  always_comb begin
    ip_hw                  = '0;
    ip_hw[EXT_INT_W-1:0]   = sync2_q;
    ip_hw[5]               = ip_hw[5] | timer_irq_q;
  end

  assign ip          = {ip_hw, ip_sw_q};
  assign int_pending = |(ip & status_q[15:8]);
  assign cause_rd    = {bd_q, 15'd0, ip, 1'b0, exc_code_q, 2'b00};

  // ---------------------------------------------------------------------------
  // Event arbitration: at most one of take_int / take_exc / take_eret is set.
  // ---------------------------------------------------------------------------
  logic       exl;
  logic       take_int, take_exc, take_eret, take_trap;
  logic [4:0] trap_code;

  assign exl       = status_q[ST_EXL];
  assign take_int  = inst_valid & status_q[ST_IE] & ~exl & int_pending;
  assign take_exc  = ~take_int & inst_valid & exc_valid;
  assign take_eret = ~take_int & ~take_exc & inst_valid & eret;
  assign take_trap = take_int | take_exc;
  assign trap_code = take_int ? 5'd0 : exc_code;

  assign flush       = take_trap | take_eret;
  assign redirect_pc = take_eret ? epc_q : EXC_VECTOR;

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; otherwise a missed case path infers a latch.
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status_q;
      REG_CAUSE:    rdata = cause_rd;
      REG_EPC:      rdata = epc_q;
      default:      rdata = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state. Order matters: timer first, then MTC0, then the taken event,
  // so that later assignments override earlier ones for the same field.
  // ---------------------------------------------------------------------------
  always_comb begin
    status_d      = status_q;
    bd_d          = bd_q;
    ip_sw_d       = ip_sw_q;
    exc_code_d    = exc_code_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    count_d       = count_q;
    compare_d     = compare_q;
    presc_d       = presc_q;
    cmp_written_d = cmp_written_q;
    timer_irq_d   = timer_irq_q;

    // Free-running timer.
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Compare is meaningless until software has programmed it once.
    if (cmp_written_q && (count_q == compare_q)) begin
      timer_irq_d = 1'b1;
    end

    if (we) begin
      case (waddr)
        REG_COUNT: begin
          count_d = wdata;
          presc_d = '0;
        end
        REG_COMPARE: begin
          compare_d     = wdata;
          cmp_written_d = 1'b1;
          timer_irq_d   = 1'b0;
        end
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        REG_CAUSE:  ip_sw_d  = wdata[9:8];
        REG_EPC:    epc_d    = wdata;
        default: ;
      endcase
    end

    if (take_trap) begin
      exc_code_d = trap_code;
      // A nested trap (EXL already set) must not lose the original return
      // address, so EPC/BD are only captured on the first-level entry.
      if (!exl) begin
        epc_d            = in_slot ? (pc - 32'd4) : pc;
        bd_d             = in_slot;
        status_d[ST_EXL] = 1'b1;
      end
      if (trap_code == 5'd4 || trap_code == 5'd5) begin
        badvaddr_d = badvaddr;
      end
    end else if (take_eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled only on the clock edge (synchronous), so resetn
  // does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      status_q      <= STATUS_RST;
      bd_q          <= 1'b0;
      ip_sw_q       <= 2'b00;
      exc_code_q    <= 5'd0;
      epc_q         <= 32'd0;
      badvaddr_q    <= 32'd0;
      count_q       <= 32'd0;
      compare_q     <= 32'd0;
      presc_q       <= '0;
      cmp_written_q <= 1'b0;
      timer_irq_q   <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
    end else begin
      status_q      <= status_d;
      bd_q          <= bd_d;
      ip_sw_q       <= ip_sw_d;
      exc_code_q    <= exc_code_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      presc_q       <= presc_d;
      cmp_written_q <= cmp_written_d;
      timer_irq_q   <= timer_irq_d;
      sync1_q       <= ext_int;
      sync2_q       <= sync1_q;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_ctrl -- self-checking bench for cp0_ctrl.
// A transaction-level model tracks the architectural CP0 registers. Every
// cycle it predicts flush / redirect_pc / int_pending / rdata. Directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_cp0_ctrl;

  localparam int unsigned EXT_INT_W  = 6;
  localparam int unsigned TIMER_DIV  = 2;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  localparam logic [4:0] R_BADV = 5'd8;
  localparam logic [4:0] R_CNT  = 5'd9;
  localparam logic [4:0] R_CMP  = 5'd11;
  localparam logic [4:0] R_STAT = 5'd12;
  localparam logic [4:0] R_CAUS = 5'd13;
  localparam logic [4:0] R_EPC  = 5'd14;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [EXT_INT_W-1:0] ext_int;
  logic [4:0]           raddr;
  logic [31:0]          rdata;
  logic                 we;
  logic [4:0]           waddr;
  logic [31:0]          wdata;
  logic                 inst_valid, exc_valid, eret, in_slot;
  logic [4:0]           exc_code;
  logic [31:0]          pc, badvaddr;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic                 int_pending;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  cp0_ctrl #(
    .EXT_INT_W (EXT_INT_W),
    .TIMER_DIV (TIMER_DIV),
    .EXC_VECTOR(EXC_VECTOR),
    .STATUS_RST(STATUS_RST)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ext_int    (ext_int),
    .raddr      (raddr),
    .rdata      (rdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .inst_valid (inst_valid),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .eret       (eret),
    .in_slot    (in_slot),
    .pc         (pc),
    .badvaddr   (badvaddr),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .int_pending(int_pending)
  );

  // ---------------------------------------------------------------------------
  // Reference model: architectural register contents
  // ---------------------------------------------------------------------------
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic        m_bd, m_cmpw, m_tirq;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  int          m_ticks;                  // clk cycles since Count last advanced/loaded
  logic [5:0]  m_ext_seen[$];            // ext_int as sampled at the most recent edges

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_status  = STATUS_RST;
    m_epc     = 0;
    m_badv    = 0;
    m_count   = 0;
    m_compare = 0;
    m_bd      = 0;
    m_cmpw    = 0;
    m_tirq    = 0;
    m_ipsw    = 0;
    m_code    = 0;
    m_ticks   = 0;
    m_ext_seen.delete();
  endtask

  // One clock cycle: inputs are already driven (after a negedge). Predict and
  // compare the combinational outputs, then advance the model at the edge.
  task automatic step();
    logic [5:0]  hw;
    logic [7:0]  ip;
    logic        pend, t_int, t_exc, t_eret, trap, old_exl, match;
    logic [4:0]  code;
    logic [31:0] exp_rd;
    #1;
    hw      = (m_ext_seen.size() == 2) ? m_ext_seen[0] : 6'd0;
    hw[5]   = hw[5] | m_tirq;
    ip      = {hw, m_ipsw};
    pend    = (ip & m_status[15:8]) != 8'd0;
    t_int   = inst_valid && m_status[0] && !m_status[1] && pend;
    t_exc   = !t_int && inst_valid && exc_valid;
    t_eret  = !t_int && !t_exc && inst_valid && eret;
    trap    = t_int || t_exc;
    code    = t_int ? 5'd0 : exc_code;
    case (raddr)
      R_BADV:  exp_rd = m_badv;
      R_CNT:   exp_rd = m_count;
      R_CMP:   exp_rd = m_compare;
      R_STAT:  exp_rd = m_status;
      R_CAUS:  exp_rd = {m_bd, 15'd0, ip, 1'b0, m_code, 2'b00};
      R_EPC:   exp_rd = m_epc;
      default: exp_rd = 0;
    endcase
    check("flush",       32'(flush),       32'(trap || t_eret));
    check("redirect_pc", redirect_pc,      t_eret ? m_epc : EXC_VECTOR);
    check("int_pending", 32'(int_pending), 32'(pend));
    check("rdata",       rdata,            exp_rd);
    old_exl = m_status[1];
    match   = m_cmpw && (m_count == m_compare);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      m_ext_seen.push_back(ext_int);
      if (m_ext_seen.size() > 2) void'(m_ext_seen.pop_front());
      m_ticks++;
      if (m_ticks == TIMER_DIV) begin
        m_ticks = 0;
        m_count = m_count + 1;
      end
      if (match) m_tirq = 1;
      if (we) begin
        case (waddr)
          R_CNT:  begin m_count = wdata; m_ticks = 0; end
          R_CMP:  begin m_compare = wdata; m_cmpw = 1; m_tirq = 0; end
          R_STAT: m_status = {m_status[31:16], wdata[15:8], m_status[7:2], wdata[1:0]};
          R_CAUS: m_ipsw = wdata[9:8];
          R_EPC:  m_epc = wdata;
          default: ;
        endcase
      end
      if (trap) begin
        m_code = code;
        if (!old_exl) begin
          m_epc       = in_slot ? pc - 4 : pc;
          m_bd        = in_slot;
          m_status[1] = 1;
        end
        if (code == 4 || code == 5) m_badv = badvaddr;
      end else if (t_eret) begin
        m_status[1] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0;
    inst_valid = 0; exc_valid = 0; exc_code = 0; eret = 0; in_slot = 0;
    pc = 0; badvaddr = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
  endtask

  // Sample a CP0 register shortly after the negedge, away from the clk edge.
  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  logic [31:0] v;
  int          n;
  logic        seen;

  initial begin
    idle();
    ext_int = 0;
    raddr   = 0;
    resetn  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // ---- reset state ----
    rd(R_STAT, v);
    check("rst_status",      v, STATUS_RST);
    check("rst_flush",       32'(flush), 0);
    check("rst_redirect",    redirect_pc, EXC_VECTOR);
    check("rst_int_pending", 32'(int_pending), 0);
    step();
    resetn = 1;

    // ---- Cause write mask and synchroniser latency ----
    mtc0(R_CAUS, 32'hFFFF_FFFF);
    rd(R_CAUS, v);
    check("cause_wmask", v, 32'h0000_0300);
    mtc0(R_CAUS, 0);
    idle(); ext_int = 6'h01; step(); ext_int = 0;
    rd(R_CAUS, v); check("ip2_after_1", 32'(v[10]), 0);
    step();
    rd(R_CAUS, v); check("ip2_after_2", 32'(v[10]), 1);
    step();
    rd(R_CAUS, v); check("ip2_gone", 32'(v[10]), 0);

    // ---- timer: Count=0, Compare=5 ----
    mtc0(R_CNT, 0);
    mtc0(R_CMP, 5);
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      idle();
      rd(R_CAUS, v);
      if (v[15]) seen = 1;
      else begin step(); n++; end
    end
    check("timer_irq_seen", 32'(seen), 1);
    check("timer_latency",  n, 10);
    rd(R_CNT, v);
    check("count_at_irq", v, 5);

    // ---- timer interrupt taken from a delay slot ----
    mtc0(R_STAT, 32'h0000_8001);
    idle(); inst_valid = 1; pc = 32'h8000_1000; in_slot = 1;
    #1;
    check("int_flush",    32'(flush), 1);
    check("int_redirect", redirect_pc, 32'hBFC0_0380);
    step();
    idle();
    rd(R_EPC,  v); check("int_epc",  v, 32'h8000_0FFC);
    rd(R_CAUS, v); check("int_bd",   32'(v[31]), 1);
                   check("int_code", 32'(v[6:2]), 0);
    rd(R_STAT, v); check("int_exl",  32'(v[1]), 1);
    mtc0(R_CMP, 100);
    rd(R_CAUS, v); check("ip7_cleared", 32'(v[15]), 0);

    // ---- ERET ----
    mtc0(R_EPC, 32'h8000_2000);
    idle(); inst_valid = 1; eret = 1;
    #1;
    check("eret_flush",    32'(flush), 1);
    check("eret_redirect", redirect_pc, 32'h8000_2000);
    step();
    idle();
    rd(R_STAT, v); check("eret_exl", 32'(v[1]), 0);

    // ---- AdEL then nested exception ----
    idle(); inst_valid = 1; exc_valid = 1; exc_code = 4;
    badvaddr = 32'h0000_0003; pc = 32'hBFC0_0100;
    #1; check("adel_flush", 32'(flush), 1);
    step();
    idle();
    rd(R_BADV, v); check("adel_badv", v, 32'h3);
    rd(R_EPC,  v); check("adel_epc",  v, 32'hBFC0_0100);
    rd(R_CAUS, v); check("adel_code", 32'(v[6:2]), 4);
    idle(); inst_valid = 1; exc_valid = 1; exc_code = 5;
    badvaddr = 32'h0000_0044; pc = 32'h8000_4000;
    step();
    idle();
    rd(R_EPC,  v); check("nested_epc_held", v, 32'hBFC0_0100);
    rd(R_BADV, v); check("nested_badv",     v, 32'h44);
    rd(R_CAUS, v); check("nested_code",     32'(v[6:2]), 5);
    idle(); inst_valid = 1; eret = 1; step();

    // ---- MTC0 Status collides with an exception ----
    idle(); we = 1; waddr = R_STAT; wdata = 0;
    inst_valid = 1; exc_valid = 1; exc_code = 5'd12; pc = 32'h8000_0040;
    step();
    idle();
    rd(R_STAT, v); check("collision_status", v, 32'h0040_0002);

    // ---- interrupt outranks a same-cycle exception ----
    mtc0(R_CAUS, 32'h0000_0100);
    mtc0(R_STAT, 32'h0000_0101);
    idle(); inst_valid = 1; exc_valid = 1; exc_code = 4; badvaddr = 32'h99;
    pc = 32'h8000_0080;
    step();
    idle();
    rd(R_CAUS, v); check("prio_code", 32'(v[6:2]), 0);
    rd(R_BADV, v); check("prio_badv", v, 32'h44);
    mtc0(R_CAUS, 0);
    mtc0(R_STAT, 0);

    // ---- events without inst_valid are ignored ----
    idle(); exc_valid = 1; eret = 1; exc_code = 4;
    #1; check("no_valid_flush", 32'(flush), 0);
    step();

    // ---- reset mid-operation drops timer irq and synchroniser ----
    mtc0(R_CMP, 3);
    mtc0(R_CNT, 3);
    idle(); ext_int = 6'h3F;
    repeat (3) step();
    rd(R_CAUS, v); check("pre_reset_ip", 32'(v[15:10]), 32'h3F);
    resetn = 0; step();
    resetn = 1; ext_int = 0;
    rd(R_CAUS, v); check("post_reset_cause", v, 0);
    step();
    rd(R_CAUS, v); check("post_reset_sync", v, 0);

    // ---- randomized phase ----
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 299) != 0);
      we     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0: waddr = R_BADV;
        1: waddr = R_CNT;
        2: waddr = R_CMP;
        3: waddr = R_STAT;
        4: waddr = R_CAUS;
        5: waddr = R_EPC;
        default: waddr = 5'($urandom);
      endcase
      wdata = $urandom;
      if (waddr == R_CNT || waddr == R_CMP) wdata = $urandom_range(0, 20);
      if (waddr == R_STAT && $urandom_range(0, 1) == 1) wdata[1] = 1'b0;
      inst_valid = ($urandom_range(0, 3) != 0);
      exc_valid  = ($urandom_range(0, 5) == 0);
      exc_code   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
      eret       = ($urandom_range(0, 5) == 0);
      in_slot    = 1'($urandom_range(0, 1));
      pc         = $urandom & 32'hFFFF_FFFC;
      badvaddr   = $urandom;
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      raddr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(8, 14)) : 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
